// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store stage: opcodes, funct3 encodings, FSM states.
// Optional build macro honoured by users of this package: LSU_MISALIGN_TRAP_EN.
package load_store_unit_pkg;

  typedef logic [31:0] word_t;
  typedef logic [6:0]  opcode_t;

  localparam opcode_t OP_LOAD  = 7'b0000011;
  localparam opcode_t OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } lsu_state_t;

  // Loads and stores share the size encoding in f3[1:0].
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    return ((f3[1:0] == 2'b01) && off[0]) || ((f3[1:0] == 2'b10) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data formatter: picks the addressed byte/halfword and sign/zero-extends it.
// Purely combinational, zero latency; no flow control.
module load_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0] f3,
  input  logic [1:0] byte_off,
  input  word_t      rdata,
  output word_t      data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte = rdata[{byte_off, 3'b000} +: 8];
    sel_half = byte_off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      LB:      data = {{24{sel_byte[7]}}, sel_byte};
      LBU:     data = {24'h0, sel_byte};
      LH:      data = {{16{sel_half[15]}}, sel_half};
      LHU:     data = {16'h0, sel_half};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: single-outstanding req/gnt/rvalid bus, load extend, store strobes.
// Latency: ALU op 1 cycle, store >=2, load >=3; stall_m holds execute while busy.
// Optional LSU_MISALIGN_TRAP_EN: misaligned accesses retire at once with err_out.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] instr_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] store_data_in,
  output logic            stall_m,
  output logic            valid_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] data_out,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            err_out,
`endif
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata
);

  lsu_state_t state, state_nxt;
  word_t      pc_q, instr_q, addr_q, sdata_q;
  word_t      load_data;
  logic       accept, is_mem_in, misalign_in, go_mem, is_store_q;
  logic [2:0] f3_q;

  assign accept     = valid_in && (state == IDLE);
  assign is_mem_in  = (instr_in[6:0] == OP_LOAD) || (instr_in[6:0] == OP_STORE);
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_in = is_mem_in && is_misaligned(instr_in[14:12], addr_in[1:0]);
`else
  assign misalign_in = 1'b0;
`endif
  assign go_mem     = is_mem_in && !misalign_in;
  assign f3_q       = instr_q[14:12];
  assign is_store_q = (instr_q[6:0] == OP_STORE);
  assign stall_m    = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && go_mem) state_nxt = REQ;
      REQ:     if (mem_gnt) state_nxt = is_store_q ? IDLE : WAIT;
      WAIT:    if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus side is a pure function of the latched instruction while in REQ.
  always_comb begin
    mem_req   = (state == REQ);
    mem_we    = mem_req && is_store_q;
    mem_addr  = {addr_q[XLEN-1:2], 2'b00};
    mem_wstrb = 4'b0000;
    mem_wdata = sdata_q;
    case (f3_q)
      SB: begin
        mem_wstrb = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{sdata_q[7:0]}};
      end
      SH: begin
        mem_wstrb = 4'b0011 << {addr_q[1], 1'b0};
        mem_wdata = {2{sdata_q[15:0]}};
      end
      default: mem_wstrb = 4'b1111;
    endcase
    if (!mem_we) mem_wstrb = 4'b0000;
  end

  load_align u_load_align (
    .f3       (f3_q),
    .byte_off (addr_q[1:0]),
    .rdata    (mem_rdata),
    .data     (load_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= '0;
      instr_q   <= '0;
      addr_q    <= '0;
      sdata_q   <= '0;
      valid_out <= 1'b0;
      pc_out    <= '0;
      instr_out <= '0;
      data_out  <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_out   <= 1'b0;
`endif
    end else begin
      valid_out <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      err_out   <= 1'b0;
`endif
      if (accept) begin
        pc_q    <= pc_in;
        instr_q <= instr_in;
        addr_q  <= addr_in;
        sdata_q <= store_data_in;
        if (!go_mem) begin
          valid_out <= 1'b1;
          pc_out    <= pc_in;
          instr_out <= instr_in;
          data_out  <= addr_in;
`ifdef LSU_MISALIGN_TRAP_EN
          err_out   <= misalign_in;
`endif
        end
      end
      if ((state == REQ) && mem_gnt && is_store_q) begin
        valid_out <= 1'b1;
        pc_out    <= pc_q;
        instr_out <= instr_q;
        data_out  <= addr_q;
      end
      if ((state == WAIT) && mem_rvalid) begin
        valid_out <= 1'b1;
        pc_out    <= pc_q;
        instr_out <= instr_q;
        data_out  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: ALU passthrough, stores, loads, reset abort,
// misaligned access (both builds of LSU_MISALIGN_TRAP_EN) and back-to-back issue.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] pc_in, instr_in, addr_in, store_data_in;
  logic        stall_m, valid_out;
  logic [31:0] pc_out, instr_out, data_out;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        err_out;
`endif
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .valid_in      (valid_in),
    .pc_in         (pc_in),
    .instr_in      (instr_in),
    .addr_in       (addr_in),
    .store_data_in (store_data_in),
    .stall_m       (stall_m),
    .valid_out     (valid_out),
    .pc_out        (pc_out),
    .instr_out     (instr_out),
    .data_out      (data_out),
`ifdef LSU_MISALIGN_TRAP_EN
    .err_out       (err_out),
`endif
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wstrb     (mem_wstrb),
    .mem_wdata     (mem_wdata),
    .mem_gnt       (mem_gnt),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata)
  );

  localparam logic [6:0] OPC_ADD = 7'b0110011;
  localparam logic [6:0] OPC_LD  = 7'b0000011;
  localparam logic [6:0] OPC_ST  = 7'b0100011;

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'h0, f3, 5'h0, op};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [31:0] ins,
                       input logic [31:0] addr, input logic [31:0] sd);
    valid_in      = 1'b1;
    pc_in         = pc;
    instr_in      = ins;
    addr_in       = addr;
    store_data_in = sd;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; valid_in = 1'b0; pc_in = '0; instr_in = '0; addr_in = '0;
    store_data_in = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    checks++; if (stall_m !== 1'b0)   begin errors++; $display("FAIL reset_stall got %b exp 0", stall_m); end
    checks++; if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid_out); end
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000)
      begin errors++; $display("FAIL reset_bus got req=%b we=%b strb=%b exp 0/0/0000", mem_req, mem_we, mem_wstrb); end
    checks++; if (data_out !== 32'h0 || pc_out !== 32'h0 || mem_addr !== 32'h0)
      begin errors++; $display("FAIL reset_data got d=%h pc=%h a=%h exp 0", data_out, pc_out, mem_addr); end
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_add;
    issue(32'h100, mk(3'b000, OPC_ADD), 32'h1234, 32'h0);
    checks++; if (valid_out !== 1'b1 || data_out !== 32'h1234 || pc_out !== 32'h100)
      begin errors++; $display("FAIL add_retire got v=%b d=%h pc=%h exp 1/00001234/00000100", valid_out, data_out, pc_out); end
    checks++; if (mem_req !== 1'b0 || stall_m !== 1'b0)
      begin errors++; $display("FAIL add_noreq got req=%b stall=%b exp 0/0", mem_req, stall_m); end
    tick();
    checks++; if (valid_out !== 1'b0 || data_out !== 32'h1234)
      begin errors++; $display("FAIL add_pulse got v=%b d=%h exp 0/00001234", valid_out, data_out); end
  endtask

  task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] sd, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input int gnt_delay);
    mem_gnt = (gnt_delay == 0);
    issue(32'h200, mk(f3, OPC_ST), addr, sd);
    for (int i = 0; i < gnt_delay; i++) begin
      checks++; if (mem_req !== 1'b1 || stall_m !== 1'b1 || valid_out !== 1'b0)
        begin errors++; $display("FAIL %s_hold got req=%b stall=%b v=%b exp 1/1/0", name, mem_req, stall_m, valid_out); end
      tick();
    end
    mem_gnt = 1'b1;
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== {addr[31:2], 2'b00})
      begin errors++; $display("FAIL %s_req got req=%b we=%b a=%h exp 1/1/%h", name, mem_req, mem_we, mem_addr, {addr[31:2], 2'b00}); end
    checks++; if (mem_wstrb !== exp_strb || mem_wdata !== exp_wdata)
      begin errors++; $display("FAIL %s_wr got strb=%b wd=%h exp %b/%h", name, mem_wstrb, mem_wdata, exp_strb, exp_wdata); end
    tick();
    mem_gnt = 1'b0;
    checks++; if (valid_out !== 1'b1 || data_out !== addr || mem_req !== 1'b0 || stall_m !== 1'b0)
      begin errors++; $display("FAIL %s_retire got v=%b d=%h req=%b stall=%b exp 1/%h/0/0", name, valid_out, data_out, mem_req, stall_m, addr); end
  endtask

  task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp,
                           input int gnt_delay, input int rv_delay);
    mem_gnt = 1'b0;
    issue(32'h300, mk(f3, OPC_LD), addr, 32'h0);
    for (int i = 0; i < gnt_delay; i++) begin
      checks++; if (mem_req !== 1'b1 || stall_m !== 1'b1 || mem_we !== 1'b0 || mem_wstrb !== 4'b0000)
        begin errors++; $display("FAIL %s_req got req=%b stall=%b we=%b strb=%b exp 1/1/0/0000", name, mem_req, stall_m, mem_we, mem_wstrb); end
      tick();
    end
    checks++; if (mem_addr !== {addr[31:2], 2'b00})
      begin errors++; $display("FAIL %s_addr got %h exp %h", name, mem_addr, {addr[31:2], 2'b00}); end
    // rvalid alongside the grant must not complete the load
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b0 || stall_m !== 1'b1 || mem_req !== 1'b0)
      begin errors++; $display("FAIL %s_wait got v=%b stall=%b req=%b exp 0/1/0", name, valid_out, stall_m, mem_req); end
    for (int i = 0; i < rv_delay; i++) tick();
    checks++; if (stall_m !== 1'b1 || valid_out !== 1'b0)
      begin errors++; $display("FAIL %s_stall got stall=%b v=%b exp 1/0", name, stall_m, valid_out); end
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b1 || data_out !== exp || pc_out !== 32'h300 || stall_m !== 1'b0)
      begin errors++; $display("FAIL %s_data got v=%b d=%h pc=%h stall=%b exp 1/%h/00000300/0", name, valid_out, data_out, pc_out, stall_m, exp); end
  endtask

  task automatic test_reset_mid_load;
    mem_gnt = 1'b1;
    issue(32'h400, mk(3'b010, OPC_LD), 32'h4000, 32'h0);
    tick();
    mem_gnt = 1'b0;
    checks++; if (stall_m !== 1'b1) begin errors++; $display("FAIL rst_mid_pre got stall=%b exp 1", stall_m); end
    #2 rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || stall_m !== 1'b0 || valid_out !== 1'b0 || data_out !== 32'h0)
      begin errors++; $display("FAIL rst_mid_async got req=%b stall=%b v=%b d=%h exp 0/0/0/0", mem_req, stall_m, valid_out, data_out); end
    tick();
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0;
    checks++; if (valid_out !== 1'b0 || stall_m !== 1'b0)
      begin errors++; $display("FAIL rst_mid_stale got v=%b stall=%b exp 0/0", valid_out, stall_m); end
  endtask

  task automatic test_misaligned_lw;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(32'h500, mk(3'b010, OPC_LD), 32'h3002, 32'h0);
    checks++; if (valid_out !== 1'b1 || err_out !== 1'b1 || data_out !== 32'h3002 || mem_req !== 1'b0)
      begin errors++; $display("FAIL mis_lw got v=%b err=%b d=%h req=%b exp 1/1/00003002/0", valid_out, err_out, data_out, mem_req); end
    tick();
    checks++; if (err_out !== 1'b0 || valid_out !== 1'b0)
      begin errors++; $display("FAIL mis_lw_pulse got err=%b v=%b exp 0/0", err_out, valid_out); end
`else
    test_load("mis_lw", 3'b010, 32'h3002, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 0);
`endif
  endtask

  task automatic test_back_to_back;
    valid_in = 1'b1; instr_in = mk(3'b000, OPC_ADD);
    pc_in = 32'h600; addr_in = 32'hA1;
    tick();
    checks++; if (valid_out !== 1'b1 || data_out !== 32'hA1)
      begin errors++; $display("FAIL b2b_first got v=%b d=%h exp 1/000000a1", valid_out, data_out); end
    pc_in = 32'h604; addr_in = 32'hB2;
    tick();
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b1 || data_out !== 32'hB2 || pc_out !== 32'h604)
      begin errors++; $display("FAIL b2b_second got v=%b d=%h pc=%h exp 1/000000b2/00000604", valid_out, data_out, pc_out); end
    // store retires, then an ADD is accepted on the very next edge
    test_store("b2b_sw", 3'b010, 32'h5004, 32'h1122_3344, 4'b1111, 32'h1122_3344, 0);
    issue(32'h608, mk(3'b000, OPC_ADD), 32'hC3, 32'h0);
    checks++; if (valid_out !== 1'b1 || data_out !== 32'hC3)
      begin errors++; $display("FAIL b2b_after_st got v=%b d=%h exp 1/000000c3", valid_out, data_out); end
  endtask

  task automatic test_ignored_inputs;
    mem_rvalid = 1'b1; mem_gnt = 1'b1;
    tick(); tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    checks++; if (valid_out !== 1'b0 || stall_m !== 1'b0 || mem_req !== 1'b0)
      begin errors++; $display("FAIL idle_ignore got v=%b stall=%b req=%b exp 0/0/0", valid_out, stall_m, mem_req); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_store("sb", 3'b000, 32'h1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 0);
    test_store("sh", 3'b001, 32'h6002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF, 2);
    test_load("lb",  3'b000, 32'h2001, 32'h0000_8000, 32'hFFFF_FF80, 3, 2);
    test_load("lbu", 3'b100, 32'h2001, 32'h0000_8000, 32'h0000_0080, 0, 0);
    test_load("lh",  3'b001, 32'h2002, 32'h8001_0000, 32'hFFFF_8001, 1, 1);
    test_load("lhu", 3'b101, 32'h2002, 32'h8001_0000, 32'h0000_8001, 0, 0);
    test_load("lw",  3'b010, 32'h2000, 32'h1234_5678, 32'h1234_5678, 0, 0);
    test_ignored_inputs();
    test_reset_mid_load();
    test_misaligned_lw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
